// File: rtl/mem_lsu.sv
// Load/store unit for the MEM stage: maps byte/halfword/word loads and stores
// onto a word-wide memory that has only a whole-word write enable. Sub-word
// stores run a read-modify-write sequence; loads are lane-extracted and
// sign- or zero-extended before they go to the MEM/WB register.
module mem_lsu #(
  parameter int AW         = 32,
  parameter bit LITTLE_END = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  input  logic [2:0]    req_op,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          req_ready,
  output logic          stall,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          mem_we,
  input  logic [31:0]   mem_rdata,
  output logic [31:0]   load_data,
  output logic          load_valid,
  output logic          misalign,
  output logic [AW-1:0] fault_addr
);

  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LBU = 3'b001;
  localparam logic [2:0] OP_LH  = 3'b010;
  localparam logic [2:0] OP_LHU = 3'b011;
  localparam logic [2:0] OP_LW  = 3'b100;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SW  = 3'b111;

  typedef enum logic [2:0] {IDLE, RD, WR, RMW_RD, RMW_WR} state_t;

  state_t          state, state_n;
  logic [2:0]      op_p0;
  logic [AW-1:0]   addr_p0;
  logic [31:0]     wdata_p0;
  logic [31:0]     merge_p1;
  logic            accept;
  logic            mis_req;

  // Bit offset of the addressed byte inside the word, honouring lane order.
  function automatic logic [4:0] byte_shift(input logic [1:0] a);
    logic [1:0] lane;
    lane = LITTLE_END ? a : ~a;
    return {lane, 3'b000};
  endfunction

  // Bit offset of the addressed halfword inside the word.
  function automatic logic [4:0] half_shift(input logic a);
    logic lane;
    lane = LITTLE_END ? a : ~a;
    return {lane, 4'b0000};
  endfunction

  // Pick the addressed lane out of a memory word and extend it to 32 bits.
  function automatic logic [31:0] extract(input logic [2:0] op, input logic [1:0] a,
                                          input logic [31:0] word);
    logic [31:0]        bword, hword;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] res;
    bword = word >> byte_shift(a);
    hword = word >> half_shift(a[1]);
    b     = signed'(bword[7:0]);
    h     = signed'(hword[15:0]);
    case (op)
      OP_LB:   res = b;
      OP_LBU:  res = {24'b0, bword[7:0]};
      OP_LH:   res = h;
      OP_LHU:  res = {16'b0, hword[15:0]};
      default: res = word;
    endcase
    return res;
  endfunction

  // Replace the addressed byte/halfword of the old word, keeping other lanes.
  function automatic logic [31:0] merge(input logic [2:0] op, input logic [1:0] a,
                                        input logic [31:0] old, input logic [15:0] wd);
    logic [31:0] mask, ins;
    if (op == OP_SH) begin
      mask = 32'h0000_FFFF << half_shift(a[1]);
      ins  = {16'b0, wd} << half_shift(a[1]);
    end else begin
      mask = 32'h0000_00FF << byte_shift(a);
      ins  = {24'b0, wd[7:0]} << byte_shift(a);
    end
    return (old & ~mask) | ins;
  endfunction

  // Alignment check on the raw request, used at acceptance.
  always_comb begin
    mis_req = 1'b0;
    case (req_op)
      OP_LH, OP_LHU, OP_SH: mis_req = req_addr[0];
      OP_LW, OP_SW:         mis_req = |req_addr[1:0];
      default:              mis_req = 1'b0;
    endcase
  end

  assign req_ready = (state == IDLE);
  assign accept    = req_valid & req_ready;
  assign stall     = req_valid & ~req_ready;
  assign mem_addr  = {addr_p0[AW-1:2], 2'b00};

  // FSM state register; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state and memory-side outputs; write enable is gated by reset.
  always_comb begin
    state_n   = state;
    mem_we    = 1'b0;
    mem_wdata = wdata_p0;
    case (state)
      IDLE: begin
        if (accept && !mis_req) begin
          if (req_op <= OP_LW)      state_n = RD;
          else if (req_op == OP_SW) state_n = WR;
          else                      state_n = RMW_RD;
        end
      end
      RD:     state_n = IDLE;
      WR: begin
        state_n = IDLE;
        mem_we  = ~rst;
      end
      RMW_RD: state_n = RMW_WR;
      RMW_WR: begin
        state_n   = IDLE;
        mem_we    = ~rst;
        mem_wdata = merge(op_p0, addr_p0[1:0], merge_p1, wdata_p0[15:0]);
      end
      default: state_n = IDLE;
    endcase
  end

  // Stage p0: request capture, misalign flag; p1: merge word and load result.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_p0      <= '0;
      addr_p0    <= '0;
      wdata_p0   <= '0;
      merge_p1   <= '0;
      load_data  <= '0;
      load_valid <= 1'b0;
      misalign   <= 1'b0;
      fault_addr <= '0;
    end else begin
      load_valid <= 1'b0;
      misalign   <= 1'b0;
      if (accept) begin
        op_p0    <= req_op;
        addr_p0  <= req_addr;
        wdata_p0 <= req_wdata;
        if (mis_req) begin
          misalign   <= 1'b1;
          fault_addr <= req_addr;
        end
      end
      if (state == RMW_RD) merge_p1 <= mem_rdata;
      if (state == RD) begin
        load_data  <= extract(op_p0, addr_p0[1:0], mem_rdata);
        load_valid <= 1'b1;
      end
    end
  end

endmodule
